// File: rtl/noc_port_request_local_pkg.sv
// Shared types for the input-port requester: output-port encoding, per-VC FSM states
// and the route-to-row one-hot helper.
package noc_port_request_local_pkg;

  localparam int Noc_VC_Channel = 4;
  localparam int NOC_PORTS      = 5;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    N     = 3'd1,
    E     = 3'd2,
    S     = 3'd3,
    W     = 3'd4
  } noc_port_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACTIVE = 2'd2
  } noc_req_state_t;

  function automatic logic route_ok(input logic [2:0] r);
    return r <= 3'(NOC_PORTS - 1);
  endfunction

  function automatic logic [NOC_PORTS-1:0] port_onehot(input noc_port_t p);
    logic [NOC_PORTS-1:0] oh;
    oh    = '0;
    oh[p] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/noc_port_request_local_if.sv
// Requester <-> output-port-controller handshake, indexed [output port][vc].
// Master drives sop/request/free/eop, slave answers with grant in the same cycle.
interface noc_port_request_local_if
  import noc_port_request_local_pkg::*;
#(
  parameter int CHANNELS = Noc_VC_Channel
) ();

  logic [NOC_PORTS-1:0][CHANNELS-1:0] start_of_packet;
  logic [NOC_PORTS-1:0][CHANNELS-1:0] request;
  logic [NOC_PORTS-1:0][CHANNELS-1:0] grant;
  logic [NOC_PORTS-1:0][CHANNELS-1:0] free;
  logic [NOC_PORTS-1:0][CHANNELS-1:0] end_of_packet;

  modport master (
    output start_of_packet, request, free, end_of_packet,
    input  grant
  );

  modport slave (
    input  start_of_packet, request, free, end_of_packet,
    output grant
  );

endinterface

// File: rtl/noc_port_request_local_vc_fsm.sv
// One VC's requester: latches the route on a head flit, pops on grant, releases on tail.
// Pop/free/eop are combinational off grant; a stalled grant simply holds the flit in its buffer.
module noc_vc_request_fsm
  import noc_port_request_local_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                 noc_clk,
  input  logic                 noc_rst_n,
  input  logic                 flit_valid_i,
  input  logic                 flit_head_i,
  input  logic                 flit_tail_i,
  input  logic [2:0]           route_i,
  input  logic [NOC_PORTS-1:0] grant_i,
  output logic                 flit_pop_o,
  output logic [2:0]           sel_port_o,
  output logic [NOC_PORTS-1:0] start_of_packet_o,
  output logic [NOC_PORTS-1:0] request_o,
  output logic [NOC_PORTS-1:0] free_o,
  output logic [NOC_PORTS-1:0] end_of_packet_o,
  output logic [CNT_W-1:0]     flit_cnt_o,
  output logic                 proto_err_o
);

  noc_req_state_t       state_q, state_d;
  noc_port_t            route_q, route_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [NOC_PORTS-1:0] row_oh;
  logic                 req;
  logic                 xfer;

  assign row_oh = port_onehot(route_q);

  always_comb begin
    state_d           = state_q;
    route_d           = route_q;
    cnt_d             = cnt_q;
    err_d             = err_q;
    req               = 1'b0;
    xfer              = 1'b0;
    flit_pop_o        = 1'b0;
    start_of_packet_o = '0;
    request_o         = '0;
    free_o            = '0;
    end_of_packet_o   = '0;

    unique case (state_q)
      IDLE: begin
        // A bad route or an orphan body flit is left in the buffer; only the flag records it.
        if (flit_valid_i) begin
          if (!flit_head_i || !route_ok(route_i)) begin
            err_d = 1'b1;
          end else begin
            route_d = noc_port_t'(route_i);
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
      end
      WAIT, ACTIVE: begin
        req               = (state_q == WAIT) ? 1'b1 : flit_valid_i;
        xfer              = req & grant_i[route_q];
        start_of_packet_o = row_oh;
        request_o         = req ? row_oh : '0;
        if (state_q == ACTIVE && flit_valid_i && flit_head_i) begin
          err_d = 1'b1;
        end
        if (xfer) begin
          flit_pop_o = 1'b1;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (flit_tail_i) begin
            free_o          = row_oh;
            end_of_packet_o = row_oh;
            state_d         = IDLE;
          end else begin
            state_d = ACTIVE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q <= IDLE;
      route_q <= LOCAL;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign sel_port_o  = route_q;
  assign flit_cnt_o  = cnt_q;
  assign proto_err_o = err_q;

endmodule

// File: rtl/noc_port_request_local.sv
// Input-port requester: one independent FSM per VC, fanned into [port][vc] control rows.
// Zero-cycle grant-to-pop; backpressure is the output controller withholding grant.
module noc_port_request_local
  import noc_port_request_local_pkg::*;
#(
  parameter int CHANNELS = Noc_VC_Channel,
  parameter int CNT_W    = 8
) (
  input  logic                            noc_clk,
  input  logic                            noc_rst_n,
  input  logic [CHANNELS-1:0]             flit_valid_i,
  input  logic [CHANNELS-1:0]             flit_head_i,
  input  logic [CHANNELS-1:0]             flit_tail_i,
  input  logic [CHANNELS-1:0][2:0]        route_i,
  output logic [CHANNELS-1:0]             flit_pop_o,
  output logic [CHANNELS-1:0][2:0]        sel_port_o,
  noc_port_request_local_if.master        port_if,
  output logic [CHANNELS-1:0][CNT_W-1:0]  flit_cnt_o,
  output logic [CHANNELS-1:0]             proto_err_o
);

  logic [NOC_PORTS-1:0] gnt_v  [CHANNELS];
  logic [NOC_PORTS-1:0] sop_v  [CHANNELS];
  logic [NOC_PORTS-1:0] req_v  [CHANNELS];
  logic [NOC_PORTS-1:0] free_v [CHANNELS];
  logic [NOC_PORTS-1:0] eop_v  [CHANNELS];

  // VC i only ever talks to column i of each output port.
  always_comb begin
    port_if.start_of_packet = '0;
    port_if.request         = '0;
    port_if.free            = '0;
    port_if.end_of_packet   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      for (int p = 0; p < NOC_PORTS; p++) begin
        gnt_v[i][p]                   = port_if.grant[p][i];
        port_if.start_of_packet[p][i] = sop_v[i][p];
        port_if.request[p][i]         = req_v[i][p];
        port_if.free[p][i]            = free_v[i][p];
        port_if.end_of_packet[p][i]   = eop_v[i][p];
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_vc
    noc_vc_request_fsm #(
      .CNT_W(CNT_W)
    ) u_fsm (
      .noc_clk          (noc_clk),
      .noc_rst_n        (noc_rst_n),
      .flit_valid_i     (flit_valid_i[i]),
      .flit_head_i      (flit_head_i[i]),
      .flit_tail_i      (flit_tail_i[i]),
      .route_i          (route_i[i]),
      .grant_i          (gnt_v[i]),
      .flit_pop_o       (flit_pop_o[i]),
      .sel_port_o       (sel_port_o[i]),
      .start_of_packet_o(sop_v[i]),
      .request_o        (req_v[i]),
      .free_o           (free_v[i]),
      .end_of_packet_o  (eop_v[i]),
      .flit_cnt_o       (flit_cnt_o[i]),
      .proto_err_o      (proto_err_o[i])
    );
  end

endmodule

// File: tb/tb_noc_port_request_local.sv
// Directed bench for the input-port requester: vector table plus hand-written
// sequences for counter saturation and mid-packet reset.
module tb_noc_port_request_local;
  import noc_port_request_local_pkg::*;

  localparam int CH = 4;
  localparam int CW = 8;
  localparam int NP = NOC_PORTS;

  typedef logic [NP-1:0][CH-1:0] grid_t;
  typedef logic [CH-1:0][2:0]    rte_t;

  typedef struct {
    string          name;
    logic [CH-1:0]  vld;
    logic [CH-1:0]  head;
    logic [CH-1:0]  tail;
    rte_t           route;
    grid_t          gnt;
    logic [CH-1:0]  pop;
    grid_t          sop;
    grid_t          req;
    grid_t          fre;
    grid_t          eop;
    logic [CW-1:0]  cnt0;
    logic [CW-1:0]  cnt1;
    logic [CH-1:0]  err;
  } vec_t;

  logic                     noc_clk = 1'b0;
  logic                     noc_rst_n;
  logic [CH-1:0]            flit_valid_i;
  logic [CH-1:0]            flit_head_i;
  logic [CH-1:0]            flit_tail_i;
  rte_t                     route_i;
  logic [CH-1:0]            flit_pop_o;
  logic [CH-1:0][2:0]       sel_port_o;
  logic [CH-1:0][CW-1:0]    flit_cnt_o;
  logic [CH-1:0]            proto_err_o;

  noc_port_request_local_if #(.CHANNELS(CH)) pif ();

  noc_port_request_local #(
    .CHANNELS(CH),
    .CNT_W   (CW)
  ) dut (
    .noc_clk     (noc_clk),
    .noc_rst_n   (noc_rst_n),
    .flit_valid_i(flit_valid_i),
    .flit_head_i (flit_head_i),
    .flit_tail_i (flit_tail_i),
    .route_i     (route_i),
    .flit_pop_o  (flit_pop_o),
    .sel_port_o  (sel_port_o),
    .port_if     (pif),
    .flit_cnt_o  (flit_cnt_o),
    .proto_err_o (proto_err_o)
  );

  always #5 noc_clk = ~noc_clk;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];

  function automatic grid_t at(input int p, input int i);
    grid_t g;
    g       = '0;
    g[p][i] = 1'b1;
    return g;
  endfunction

  function automatic rte_t rt(input logic [2:0] r0, input logic [2:0] r1);
    rte_t r;
    r    = '0;
    r[0] = r0;
    r[1] = r1;
    return r;
  endfunction

  function automatic vec_t mk(input string nm,
                              input logic [CH-1:0] vld, head, tail,
                              input rte_t route, input grid_t gnt,
                              input logic [CH-1:0] pop,
                              input grid_t sop, req, fre, eop,
                              input logic [CW-1:0] c0, c1,
                              input logic [CH-1:0] err);
    vec_t v;
    v.name = nm;  v.vld = vld;  v.head = head;  v.tail = tail;
    v.route = route;  v.gnt = gnt;  v.pop = pop;
    v.sop = sop;  v.req = req;  v.fre = fre;  v.eop = eop;
    v.cnt0 = c0;  v.cnt1 = c1;  v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [CH-1:0] vld, head, tail, input rte_t route, input grid_t gnt);
    flit_valid_i = vld;
    flit_head_i  = head;
    flit_tail_i  = tail;
    route_i      = route;
    pif.grant    = gnt;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".pop"},  64'(flit_pop_o), 64'd0);
    chk({nm, ".sop"},  64'(pif.start_of_packet), 64'd0);
    chk({nm, ".req"},  64'(pif.request), 64'd0);
    chk({nm, ".free"}, 64'(pif.free), 64'd0);
    chk({nm, ".eop"},  64'(pif.end_of_packet), 64'd0);
    chk({nm, ".cnt"},  64'(flit_cnt_o), 64'd0);
    chk({nm, ".err"},  64'(proto_err_o), 64'd0);
    chk({nm, ".sel"},  64'(sel_port_o), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    grid_t b4;
    int    pops;
    int    eops;

    noc_rst_n = 1'b0;
    drive('0, '0, '0, '0, '0);
    b4 = at(4, 0) | at(4, 1);

    // 4-flit packet, VC0 -> port 2, granted on request
    tbl.push_back(mk("p4_idle",  4'b0001, 4'b0001, 4'b0000, rt(3'd2, 3'd0), '0,       4'b0000, '0,       '0,       '0,       '0,       8'd0, 8'd0, 4'b0000));
    tbl.push_back(mk("p4_wait",  4'b0001, 4'b0001, 4'b0000, rt(3'd2, 3'd0), at(2, 0), 4'b0001, at(2, 0), at(2, 0), '0,       '0,       8'd0, 8'd0, 4'b0000));
    tbl.push_back(mk("p4_b1",    4'b0001, 4'b0000, 4'b0000, '0,             at(2, 0), 4'b0001, at(2, 0), at(2, 0), '0,       '0,       8'd1, 8'd0, 4'b0000));
    tbl.push_back(mk("p4_b2",    4'b0001, 4'b0000, 4'b0000, '0,             at(2, 0), 4'b0001, at(2, 0), at(2, 0), '0,       '0,       8'd2, 8'd0, 4'b0000));
    tbl.push_back(mk("p4_tail",  4'b0001, 4'b0000, 4'b0001, '0,             at(2, 0), 4'b0001, at(2, 0), at(2, 0), at(2, 0), at(2, 0), 8'd3, 8'd0, 4'b0000));
    tbl.push_back(mk("p4_after", 4'b0000, 4'b0000, 4'b0000, '0,             '0,       4'b0000, '0,       '0,       '0,       '0,       8'd4, 8'd0, 4'b0000));
    // single-flit packet, VC1 -> port 0, grant two cycles late; stray grants afterwards
    tbl.push_back(mk("s1_idle",  4'b0010, 4'b0010, 4'b0010, '0, '0,       4'b0000, '0,       '0,       '0,       '0,       8'd4, 8'd0, 4'b0000));
    tbl.push_back(mk("s1_w1",    4'b0010, 4'b0010, 4'b0010, '0, '0,       4'b0000, at(0, 1), at(0, 1), '0,       '0,       8'd4, 8'd0, 4'b0000));
    tbl.push_back(mk("s1_w2",    4'b0010, 4'b0010, 4'b0010, '0, '0,       4'b0000, at(0, 1), at(0, 1), '0,       '0,       8'd4, 8'd0, 4'b0000));
    tbl.push_back(mk("s1_gnt",   4'b0010, 4'b0010, 4'b0010, '0, at(0, 1), 4'b0010, at(0, 1), at(0, 1), at(0, 1), at(0, 1), 8'd4, 8'd0, 4'b0000));
    tbl.push_back(mk("s1_after", 4'b0000, 4'b0000, 4'b0000, '0, at(0, 1) | at(2, 0), 4'b0000, '0, '0,    '0,       '0,       8'd4, 8'd1, 4'b0000));
    // VC0 -> port 3, grant 1,0,0,1,1 with a valid gap and a wrong-port grant
    tbl.push_back(mk("t3_idle",  4'b0001, 4'b0001, 4'b0000, rt(3'd3, 3'd0), '0,       4'b0000, '0,       '0,       '0,       '0,       8'd4, 8'd1, 4'b0000));
    tbl.push_back(mk("t3_g1",    4'b0001, 4'b0001, 4'b0000, rt(3'd3, 3'd0), at(3, 0), 4'b0001, at(3, 0), at(3, 0), '0,       '0,       8'd0, 8'd1, 4'b0000));
    tbl.push_back(mk("t3_gap",   4'b0000, 4'b0000, 4'b0000, '0,             '0,       4'b0000, at(3, 0), '0,       '0,       '0,       8'd1, 8'd1, 4'b0000));
    tbl.push_back(mk("t3_wrong", 4'b0001, 4'b0000, 4'b0000, '0,             at(2, 0), 4'b0000, at(3, 0), at(3, 0), '0,       '0,       8'd1, 8'd1, 4'b0000));
    tbl.push_back(mk("t3_g1b",   4'b0001, 4'b0000, 4'b0000, '0,             at(3, 0), 4'b0001, at(3, 0), at(3, 0), '0,       '0,       8'd1, 8'd1, 4'b0000));
    tbl.push_back(mk("t3_tail",  4'b0001, 4'b0000, 4'b0001, '0,             at(3, 0), 4'b0001, at(3, 0), at(3, 0), at(3, 0), at(3, 0), 8'd2, 8'd1, 4'b0000));
    tbl.push_back(mk("t3_after", 4'b0000, 4'b0000, 4'b0000, '0,             '0,       4'b0000, '0,       '0,       '0,       '0,       8'd3, 8'd1, 4'b0000));
    // VC0 and VC1 both -> port 4, grants interleaved
    tbl.push_back(mk("t4_idle",  4'b0011, 4'b0011, 4'b0000, rt(3'd4, 3'd4), '0,       4'b0000, '0,       '0,       '0,       '0,       8'd3, 8'd1, 4'b0000));
    tbl.push_back(mk("t4_g0",    4'b0011, 4'b0011, 4'b0000, rt(3'd4, 3'd4), at(4, 0), 4'b0001, b4,       b4,       '0,       '0,       8'd0, 8'd0, 4'b0000));
    tbl.push_back(mk("t4_g1",    4'b0011, 4'b0010, 4'b0001, rt(3'd0, 3'd4), at(4, 1), 4'b0010, b4,       b4,       '0,       '0,       8'd1, 8'd0, 4'b0000));
    tbl.push_back(mk("t4_eop0",  4'b0011, 4'b0000, 4'b0011, '0,             at(4, 0), 4'b0001, b4,       b4,       at(4, 0), at(4, 0), 8'd1, 8'd1, 4'b0000));
    tbl.push_back(mk("t4_eop1",  4'b0010, 4'b0000, 4'b0010, '0,             at(4, 1), 4'b0010, at(4, 1), at(4, 1), at(4, 1), at(4, 1), 8'd2, 8'd1, 4'b0000));
    tbl.push_back(mk("t4_after", 4'b0000, 4'b0000, 4'b0000, '0,             '0,       4'b0000, '0,       '0,       '0,       '0,       8'd2, 8'd2, 4'b0000));
    // protocol errors: bad route on VC0, second head mid-packet on VC1, orphan body on VC2
    tbl.push_back(mk("e_route",  4'b0001, 4'b0001, 4'b0000, rt(3'd6, 3'd0), '0,       4'b0000, '0,       '0,       '0,       '0,       8'd2, 8'd2, 4'b0000));
    tbl.push_back(mk("e_hold",   4'b0001, 4'b0001, 4'b0000, rt(3'd6, 3'd0), '0,       4'b0000, '0,       '0,       '0,       '0,       8'd2, 8'd2, 4'b0001));
    tbl.push_back(mk("e_clear",  4'b0000, 4'b0000, 4'b0000, '0,             '0,       4'b0000, '0,       '0,       '0,       '0,       8'd2, 8'd2, 4'b0001));
    tbl.push_back(mk("e_h1",     4'b0010, 4'b0010, 4'b0000, rt(3'd0, 3'd1), '0,       4'b0000, '0,       '0,       '0,       '0,       8'd2, 8'd2, 4'b0001));
    tbl.push_back(mk("e_w1",     4'b0010, 4'b0010, 4'b0000, rt(3'd0, 3'd1), at(1, 1), 4'b0010, at(1, 1), at(1, 1), '0,       '0,       8'd2, 8'd0, 4'b0001));
    tbl.push_back(mk("e_h2",     4'b0010, 4'b0010, 4'b0000, rt(3'd0, 3'd1), at(1, 1), 4'b0010, at(1, 1), at(1, 1), '0,       '0,       8'd2, 8'd1, 4'b0001));
    tbl.push_back(mk("e_tail",   4'b0010, 4'b0000, 4'b0010, '0,             at(1, 1), 4'b0010, at(1, 1), at(1, 1), at(1, 1), at(1, 1), 8'd2, 8'd2, 4'b0011));
    tbl.push_back(mk("e_orphan", 4'b0100, 4'b0000, 4'b0000, '0,             '0,       4'b0000, '0,       '0,       '0,       '0,       8'd2, 8'd3, 4'b0011));
    tbl.push_back(mk("e_final",  4'b0000, 4'b0000, 4'b0000, '0,             '0,       4'b0000, '0,       '0,       '0,       '0,       8'd2, 8'd3, 4'b0111));

    repeat (2) @(negedge noc_clk);
    #4;
    chk_all_zero("reset");
    @(negedge noc_clk);
    noc_rst_n = 1'b1;

    foreach (tbl[k]) begin
      drive(tbl[k].vld, tbl[k].head, tbl[k].tail, tbl[k].route, tbl[k].gnt);
      #4;
      chk($sformatf("%s.pop",  tbl[k].name), 64'(flit_pop_o),            64'(tbl[k].pop));
      chk($sformatf("%s.sop",  tbl[k].name), 64'(pif.start_of_packet),   64'(tbl[k].sop));
      chk($sformatf("%s.req",  tbl[k].name), 64'(pif.request),           64'(tbl[k].req));
      chk($sformatf("%s.free", tbl[k].name), 64'(pif.free),              64'(tbl[k].fre));
      chk($sformatf("%s.eop",  tbl[k].name), 64'(pif.end_of_packet),     64'(tbl[k].eop));
      chk($sformatf("%s.cnt0", tbl[k].name), 64'(flit_cnt_o[0]),         64'(tbl[k].cnt0));
      chk($sformatf("%s.cnt1", tbl[k].name), 64'(flit_cnt_o[1]),         64'(tbl[k].cnt1));
      chk($sformatf("%s.err",  tbl[k].name), 64'(proto_err_o),           64'(tbl[k].err));
      @(negedge noc_clk);
    end

    drive('0, '0, '0, '0, '0);
    #4;
    chk("sel_vc0", 64'(sel_port_o[0]), 64'd4);
    chk("sel_vc1", 64'(sel_port_o[1]), 64'd1);
    chk("sel_vc2", 64'(sel_port_o[2]), 64'd0);
    @(negedge noc_clk);

    // 260-flit packet on VC3 -> port 0: counter must stop at 255
    pops = 0;
    eops = 0;
    for (int k = 0; k <= 261; k++) begin
      if (k <= 260) begin
        drive(4'b1000, (k <= 1) ? 4'b1000 : 4'b0000, (k == 260) ? 4'b1000 : 4'b0000, '0, at(0, 3));
      end else begin
        drive('0, '0, '0, '0, '0);
      end
      #4;
      if (flit_pop_o[3]) pops++;
      if (pif.end_of_packet[0][3]) eops++;
      @(negedge noc_clk);
    end
    #4;
    chk("sat_cnt3", 64'(flit_cnt_o[3]), 64'd255);
    chk("sat_pops", 64'(pops), 64'd260);
    chk("sat_eops", 64'(eops), 64'd1);
    chk("sat_err",  64'(proto_err_o), 64'b0111);
    @(negedge noc_clk);

    // reset while VC0 is ACTIVE and transferring
    drive(4'b0001, 4'b0001, 4'b0000, rt(3'd2, 3'd0), '0);
    @(negedge noc_clk);
    drive(4'b0001, 4'b0001, 4'b0000, rt(3'd2, 3'd0), at(2, 0));
    @(negedge noc_clk);
    drive(4'b0001, 4'b0000, 4'b0000, '0, at(2, 0));
    #2;
    chk("pre_rst.pop", 64'(flit_pop_o), 64'b0001);
    noc_rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    drive('0, '0, '0, '0, '0);
    @(negedge noc_clk);
    noc_rst_n = 1'b1;
    drive(4'b0001, 4'b0001, 4'b0001, rt(3'd1, 3'd0), '0);
    #4;
    chk("post_rst_idle.sop", 64'(pif.start_of_packet), 64'd0);
    @(negedge noc_clk);
    drive(4'b0001, 4'b0001, 4'b0001, rt(3'd1, 3'd0), at(1, 0));
    #4;
    chk("post_rst_gnt.sop", 64'(pif.start_of_packet), 64'(at(1, 0)));
    chk("post_rst_gnt.pop", 64'(flit_pop_o), 64'b0001);
    chk("post_rst_gnt.eop", 64'(pif.end_of_packet), 64'(at(1, 0)));
    @(negedge noc_clk);
    drive('0, '0, '0, '0, '0);
    #4;
    chk("post_rst_done.sop",  64'(pif.start_of_packet), 64'd0);
    chk("post_rst_done.cnt0", 64'(flit_cnt_o[0]), 64'd1);
    chk("post_rst_done.sel0", 64'(sel_port_o[0]), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
